// File: rtl/mult_complex_if.sv
// Operand/result bundle for the pipelined complex multiplier.
// The master drives the sample, the coefficient and the stall control.
// The slave (the multiplier) returns the registered product.
interface mult_complex_if #(
    parameter int unsigned DATA_WIDTH = 16
);
    logic                         en;
    logic                         valid_in;
    logic signed [DATA_WIDTH-1:0] data_in_i;
    logic signed [DATA_WIDTH-1:0] data_in_q;
    logic signed [DATA_WIDTH-1:0] coef_i;
    logic signed [DATA_WIDTH-1:0] coef_q;
    logic                         valid_out;
    logic signed [DATA_WIDTH-1:0] data_out_i;
    logic signed [DATA_WIDTH-1:0] data_out_q;
    logic                         sat_flag;

    modport master (
        output en,
        output valid_in,
        output data_in_i,
        output data_in_q,
        output coef_i,
        output coef_q,
        input  valid_out,
        input  data_out_i,
        input  data_out_q,
        input  sat_flag
    );

    modport slave (
        input  en,
        input  valid_in,
        input  data_in_i,
        input  data_in_q,
        input  coef_i,
        input  coef_q,
        output valid_out,
        output data_out_i,
        output data_out_q,
        output sat_flag
    );
endinterface

// File: rtl/mult_complex.sv
// Three-stage signed complex multiplier, Q1.(DATA_WIDTH-1) in and out.
// S1 registers the operands, S2 forms the four partial products, and S3 combines,
// rounds half up and saturates them. A single enable stalls every register, and a
// 3-bit valid chain travels with the data.
module mult_complex #(
    parameter int unsigned DATA_WIDTH = 16
) (
    input  logic          clk,
    input  logic          rst,
    mult_complex_if.slave bus
);
    localparam int unsigned PW = 2 * DATA_WIDTH;   // full product width
    localparam int unsigned SW = PW + 1;           // sum/difference width, no overflow

    typedef logic signed [DATA_WIDTH-1:0] samp_t;
    typedef logic signed [PW-1:0]         prod_t;
    typedef logic signed [SW-1:0]         sum_t;

    // Round half up, drop the DATA_WIDTH-1 fraction bits, and clip to the output range.
    // Returns {clipped, value}.
    function automatic logic [DATA_WIDTH:0] round_sat(input sum_t x);
        sum_t rnd;
        sum_t hi;
        sum_t lo;
        sum_t r;
        rnd                   = '0;
        rnd[DATA_WIDTH-2]     = 1'b1;
        hi                    = '0;
        hi[DATA_WIDTH-2:0]    = '1;
        lo                    = '1;
        lo[DATA_WIDTH-2:0]    = '0;
        r = (x + rnd) >>> (DATA_WIDTH - 1);
        if (r > hi) begin
            round_sat = {1'b1, hi[DATA_WIDTH-1:0]};
        end else if (r < lo) begin
            round_sat = {1'b1, lo[DATA_WIDTH-1:0]};
        end else begin
            round_sat = {1'b0, r[DATA_WIDTH-1:0]};
        end
    endfunction

    // Operand registers (S1)
    samp_t a_q;
    samp_t b_q;
    samp_t c_q;
    samp_t d_q;

    // Partial product registers (S2)
    prod_t pr1_q;
    prod_t pr2_q;
    prod_t pi1_q;
    prod_t pi2_q;
    prod_t pr1_d;
    prod_t pr2_d;
    prod_t pi1_d;
    prod_t pi2_d;

    // Output registers (S3)
    samp_t re_q;
    samp_t im_q;
    logic  sat_q;
    samp_t re_d;
    samp_t im_d;
    logic  sat_d;
    sum_t  re_sum;
    sum_t  im_sum;
    logic  sat_re;
    logic  sat_im;

    // valid_q[0] tracks S1, valid_q[2] tracks the output stage
    logic [2:0] valid_q;

    // S1: capture the operands on every enabled edge, valid or not
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q <= '0;
            b_q <= '0;
            c_q <= '0;
            d_q <= '0;
        end else if (bus.en) begin
            a_q <= bus.data_in_i;
            b_q <= bus.data_in_q;
            c_q <= bus.coef_i;
            d_q <= bus.coef_q;
        end
    end

    // S2 next state: the four full-width signed partial products
    always_comb begin
        pr1_d = prod_t'(a_q) * prod_t'(c_q);
        pr2_d = prod_t'(b_q) * prod_t'(d_q);
        pi1_d = prod_t'(a_q) * prod_t'(d_q);
        pi2_d = prod_t'(b_q) * prod_t'(c_q);
    end

    // S2: hold the partial products
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pr1_q <= '0;
            pr2_q <= '0;
            pi1_q <= '0;
            pi2_q <= '0;
        end else if (bus.en) begin
            pr1_q <= pr1_d;
            pr2_q <= pr2_d;
            pi1_q <= pi1_d;
            pi2_q <= pi2_d;
        end
    end

    // S3 next state: combine one bit wider than the products, then round and clip
    always_comb begin
        re_sum           = sum_t'(pr1_q) - sum_t'(pr2_q);
        im_sum           = sum_t'(pi1_q) + sum_t'(pi2_q);
        {sat_re, re_d}   = round_sat(re_sum);
        {sat_im, im_d}   = round_sat(im_sum);
        sat_d            = sat_re | sat_im;
    end

    // S3: registered outputs, including the saturation flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            re_q  <= '0;
            im_q  <= '0;
            sat_q <= 1'b0;
        end else if (bus.en) begin
            re_q  <= re_d;
            im_q  <= im_d;
            sat_q <= sat_d;
        end
    end

    // Valid shift chain, stalled together with the data
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
        end else if (bus.en) begin
            valid_q <= {valid_q[1:0], bus.valid_in};
        end
    end

    assign bus.valid_out  = valid_q[2];
    assign bus.data_out_i = re_q;
    assign bus.data_out_q = im_q;
    assign bus.sat_flag   = sat_q;

endmodule

// File: tb/tb_mult_complex.sv
// Self-checking bench for mult_complex: directed corner cases, asynchronous reset,
// random stalls, and a back-to-back random stream checked against an arithmetic model.
module tb_mult_complex;
    localparam int W = 16;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_pass   = 0;

    always #5 clk = ~clk;

    mult_complex_if #(.DATA_WIDTH(W)) bus ();

    mult_complex #(.DATA_WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Exact complex product in Q1.15: round half up, clip. Returns {sat, re, im}.
    function automatic logic [2*W:0] ref_mul(input int a, input int b, input int c, input int d);
        longint re;
        longint im;
        logic   sat;
        sat = 1'b0;
        re  = longint'(a) * longint'(c) - longint'(b) * longint'(d);
        im  = longint'(a) * longint'(d) + longint'(b) * longint'(c);
        re  = (re + 64'sd16384) >>> 15;
        im  = (im + 64'sd16384) >>> 15;
        if (re > 32767)  begin re = 32767;  sat = 1'b1; end
        if (re < -32768) begin re = -32768; sat = 1'b1; end
        if (im > 32767)  begin im = 32767;  sat = 1'b1; end
        if (im < -32768) begin im = -32768; sat = 1'b1; end
        return {sat, re[W-1:0], im[W-1:0]};
    endfunction

    // Random operand with extra weight on the range ends
    function automatic int rnd_samp();
        logic signed [W-1:0] v;
        case ($urandom_range(0, 7))
            0:       return -32768;
            1:       return 32767;
            default: begin
                v = W'($urandom);
                return int'(v);
            end
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input int a, input int b, input int c, input int d);
        bus.valid_in  = v;
        bus.data_in_i = W'(a);
        bus.data_in_q = W'(b);
        bus.coef_i    = W'(c);
        bus.coef_q    = W'(d);
    endtask

    // Push one sample followed by invalid filler, return what appears 3 edges later
    task automatic run_single(input int a, input int b, input int c, input int d,
                              output logic vo, output int oi, output int oq, output logic sat);
        bus.en = 1'b1;
        drive(1'b1, a, b, c, d);
        tick();
        drive(1'b0, rnd_samp(), rnd_samp(), rnd_samp(), rnd_samp());
        tick();
        tick();
        vo  = bus.valid_out;
        oi  = int'(bus.data_out_i);
        oq  = int'(bus.data_out_q);
        sat = bus.sat_flag;
    endtask

    task automatic test_reset();
        rst    = 1'b1;
        bus.en = 1'b0;
        drive(1'b0, 0, 0, 0, 0);
        #1;
        n_checks++;
        if ({bus.valid_out, bus.data_out_i, bus.data_out_q, bus.sat_flag} !== '0)
            $display("FAIL reset_initial: got v=%b i=%0d q=%0d sat=%b, want all 0",
                     bus.valid_out, bus.data_out_i, bus.data_out_q, bus.sat_flag);
        else n_pass++;
        bus.en = 1'b1;
        drive(1'b1, 1234, -55, 32767, 77);
        tick();
        tick();
        n_checks++;
        if ({bus.valid_out, bus.data_out_i, bus.data_out_q, bus.sat_flag} !== '0)
            $display("FAIL reset_held: got v=%b i=%0d q=%0d sat=%b, want all 0",
                     bus.valid_out, bus.data_out_i, bus.data_out_q, bus.sat_flag);
        else n_pass++;
        drive(1'b0, 0, 0, 0, 0);
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick();
            n_checks++;
            if (bus.valid_out !== 1'b0)
                $display("FAIL reset_release_c%0d: valid_out=%b, want 0", k, bus.valid_out);
            else n_pass++;
        end
    endtask

    task automatic test_basic();
        logic vo;
        logic sat;
        int   oi;
        int   oq;
        run_single(16384, 0, 0, 32767, vo, oi, oq, sat);
        n_checks++;
        if (vo !== 1'b1 || oi != 0 || oq != 16384 || sat !== 1'b0)
            $display("FAIL basic_rot: got v=%b (%0d,%0d) sat=%b, want v=1 (0,16384) sat=0",
                     vo, oi, oq, sat);
        else n_pass++;
        run_single(1000, 2000, 32767, 0, vo, oi, oq, sat);
        n_checks++;
        if (vo !== 1'b1 || oi != 1000 || oq != 2000 || sat !== 1'b0)
            $display("FAIL basic_unity: got v=%b (%0d,%0d) sat=%b, want v=1 (1000,2000) sat=0",
                     vo, oi, oq, sat);
        else n_pass++;
    endtask

    task automatic test_rounding();
        logic vo;
        logic sat;
        int   oi;
        int   oq;
        run_single(-1, 0, 16384, 0, vo, oi, oq, sat);
        n_checks++;
        if (vo !== 1'b1 || oi != 0 || oq != 0 || sat !== 1'b0)
            $display("FAIL round_tie: got v=%b (%0d,%0d) sat=%b, want v=1 (0,0) sat=0",
                     vo, oi, oq, sat);
        else n_pass++;
        run_single(3, 0, 16384, 0, vo, oi, oq, sat);
        n_checks++;
        if (vo !== 1'b1 || oi != 2 || oq != 0 || sat !== 1'b0)
            $display("FAIL round_up: got v=%b (%0d,%0d) sat=%b, want v=1 (2,0) sat=0",
                     vo, oi, oq, sat);
        else n_pass++;
    endtask

    task automatic test_saturation();
        logic vo;
        logic sat;
        int   oi;
        int   oq;
        run_single(-32768, 0, -32768, 0, vo, oi, oq, sat);
        n_checks++;
        if (vo !== 1'b1 || oi != 32767 || oq != 0 || sat !== 1'b1)
            $display("FAIL sat_real: got v=%b (%0d,%0d) sat=%b, want v=1 (32767,0) sat=1",
                     vo, oi, oq, sat);
        else n_pass++;
        run_single(-32768, -32768, -32768, -32768, vo, oi, oq, sat);
        n_checks++;
        if (vo !== 1'b1 || oi != 0 || oq != 32767 || sat !== 1'b1)
            $display("FAIL sat_imag: got v=%b (%0d,%0d) sat=%b, want v=1 (0,32767) sat=1",
                     vo, oi, oq, sat);
        else n_pass++;
    endtask

    task automatic test_reset_midstream();
        bus.en = 1'b1;
        drive(1'b1, -32768, 0, -32768, 0);
        tick();
        drive(1'b1, 1000, 2000, 32767, 0);
        tick();
        drive(1'b1, 16384, 0, 0, 32767);
        tick();
        n_checks++;
        if (bus.valid_out !== 1'b1 || bus.sat_flag !== 1'b1)
            $display("FAIL midreset_pre: got v=%b sat=%b, want v=1 sat=1",
                     bus.valid_out, bus.sat_flag);
        else n_pass++;
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if ({bus.valid_out, bus.data_out_i, bus.data_out_q, bus.sat_flag} !== '0)
            $display("FAIL midreset_async: got v=%b i=%0d q=%0d sat=%b, want all 0",
                     bus.valid_out, bus.data_out_i, bus.data_out_q, bus.sat_flag);
        else n_pass++;
        tick();
        tick();
        n_checks++;
        if ({bus.valid_out, bus.data_out_i, bus.data_out_q, bus.sat_flag} !== '0)
            $display("FAIL midreset_hold: got v=%b i=%0d q=%0d sat=%b, want all 0",
                     bus.valid_out, bus.data_out_i, bus.data_out_q, bus.sat_flag);
        else n_pass++;
        drive(1'b0, 0, 0, 0, 0);
        rst = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick();
            n_checks++;
            if ({bus.valid_out, bus.data_out_i, bus.data_out_q, bus.sat_flag} !== '0)
                $display("FAIL midreset_stale_c%0d: got v=%b i=%0d q=%0d sat=%b, want all 0",
                         k, bus.valid_out, bus.data_out_i, bus.data_out_q, bus.sat_flag);
            else n_pass++;
        end
    endtask

    task automatic test_stall();
        int             sa[8];
        int             sb[8];
        int             sc[8];
        int             sd[8];
        logic [2*W:0]   exp_q[$];
        logic [2*W:0]   obs;
        logic [2*W:0]   want;
        logic [2*W+1:0] prev;
        logic [2*W+1:0] cur;
        logic           en_now;
        int             idx;
        int             got;
        for (int i = 0; i < 8; i++) begin
            sa[i] = rnd_samp();
            sb[i] = rnd_samp();
            sc[i] = rnd_samp();
            sd[i] = rnd_samp();
        end
        idx  = 0;
        got  = 0;
        prev = {bus.valid_out, bus.sat_flag, bus.data_out_i, bus.data_out_q};
        for (int cyc = 0; cyc < 200 && got < 8; cyc++) begin
            en_now = 1'($urandom_range(0, 1));
            bus.en = en_now;
            if (idx < 8) drive(1'b1, sa[idx], sb[idx], sc[idx], sd[idx]);
            else         drive(1'b0, rnd_samp(), rnd_samp(), rnd_samp(), rnd_samp());
            tick();
            cur = {bus.valid_out, bus.sat_flag, bus.data_out_i, bus.data_out_q};
            if (en_now) begin
                if (idx < 8) begin
                    exp_q.push_back(ref_mul(sa[idx], sb[idx], sc[idx], sd[idx]));
                    idx++;
                end
                if (bus.valid_out === 1'b1) begin
                    obs = {bus.sat_flag, bus.data_out_i, bus.data_out_q};
                    want = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
                    n_checks++;
                    if (obs !== want)
                        $display("FAIL stall_data_%0d: got sat=%b (%0d,%0d), want sat=%b (%0d,%0d)",
                                 got, obs[2*W], $signed(obs[2*W-1:W]), $signed(obs[W-1:0]),
                                 want[2*W], $signed(want[2*W-1:W]), $signed(want[W-1:0]));
                    else n_pass++;
                    got++;
                end
            end else begin
                n_checks++;
                if (cur !== prev)
                    $display("FAIL stall_hold_c%0d: outputs moved %h -> %h while en=0",
                             cyc, prev, cur);
                else n_pass++;
            end
            prev = cur;
        end
        n_checks++;
        if (got != 8 || exp_q.size() != 0)
            $display("FAIL stall_count: got %0d products (%0d pending), want 8 (0 pending)",
                     got, exp_q.size());
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        int           sa[64];
        int           sb[64];
        int           sc[64];
        int           sd[64];
        logic [2*W:0] obs;
        logic [2*W:0] want;
        logic         want_v;
        for (int i = 0; i < 64; i++) begin
            sa[i] = rnd_samp();
            sb[i] = rnd_samp();
            sc[i] = rnd_samp();
            sd[i] = rnd_samp();
        end
        bus.en = 1'b1;
        drive(1'b0, 0, 0, 0, 0);
        tick();
        tick();
        tick();
        // Sample j-1 is presented before edge j; its product is visible after edge j+2
        for (int j = 1; j <= 70; j++) begin
            if (j - 1 < 64) drive(1'b1, sa[j-1], sb[j-1], sc[j-1], sd[j-1]);
            else            drive(1'b0, rnd_samp(), rnd_samp(), rnd_samp(), rnd_samp());
            tick();
            want_v = (j >= 3 && j <= 66);
            n_checks++;
            if (bus.valid_out !== want_v)
                $display("FAIL b2b_valid_e%0d: valid_out=%b, want %b", j, bus.valid_out, want_v);
            else n_pass++;
            if (want_v) begin
                obs  = {bus.sat_flag, bus.data_out_i, bus.data_out_q};
                want = ref_mul(sa[j-3], sb[j-3], sc[j-3], sd[j-3]);
                n_checks++;
                if (obs !== want)
                    $display("FAIL b2b_data_%0d: got sat=%b (%0d,%0d), want sat=%b (%0d,%0d)",
                             j - 3, obs[2*W], $signed(obs[2*W-1:W]), $signed(obs[W-1:0]),
                             want[2*W], $signed(want[2*W-1:W]), $signed(want[W-1:0]));
                else n_pass++;
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_rounding();
        test_saturation();
        test_reset_midstream();
        test_stall();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
